// File: rtl/lfsr_cipher_duplex.sv
// Full-duplex W-bit LFSR stream cipher: independent TX/RX keystream generators sharing one serial config chain.
// Optional build macro CIPHER_RESYNC_EN adds a per-channel frame counter that reloads the seed every FRAME_LEN beats.
// Handshake: a beat moves on a rising edge where valid & ready are both high; an output beat holds stable while valid & !ready.
module lfsr_cipher_duplex #(
  parameter int           M            = 32,
  parameter int           W            = 1,
  parameter logic [M-1:0] TAPS_DEFAULT = M'(32'h80200003),
  parameter logic [M-1:0] SEED_DEFAULT = M'(32'h00000001)
`ifdef CIPHER_RESYNC_EN
  ,
  parameter int           FRAME_LEN    = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_en,
  input  logic         cfg_i,
  output logic         cfg_o,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic [W-1:0] tx_data,
  output logic         txo_valid,
  input  logic         txo_ready,
  output logic [W-1:0] txo_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [W-1:0] rx_data,
  output logic         rxo_valid,
  input  logic         rxo_ready,
  output logic [W-1:0] rxo_data
);
  localparam int CW = 2 * M + 2;

  logic [CW-1:0] r_cfg;
  logic          r_cfg_en_d;
  logic [M-1:0]  r_tx_lfsr, r_rx_lfsr;
  logic          r_txo_valid, r_rxo_valid;
  logic [W-1:0]  r_txo_data, r_rxo_data;

  logic [1:0]     w_mode;
  logic [M-1:0]   w_taps_eff, w_seed_eff;
  logic           w_cfg_load, w_bypass, w_rx_freeze;
  logic           w_tx_fire, w_rx_fire;
  logic [M+W-1:0] w_tx_run, w_rx_run;
  logic [M-1:0]   w_tx_step, w_rx_step, w_tx_lfsr_nxt, w_rx_lfsr_nxt;
  logic [W-1:0]   w_tx_ks, w_rx_ks;

  // W Fibonacci steps in one cycle; returns {next_state, keystream bits with step 0 in bit 0}.
  function automatic logic [M+W-1:0] lfsr_run(input logic [M-1:0] s_in, input logic [M-1:0] taps);
    logic [M-1:0] s;
    logic [W-1:0] ks;
    s  = s_in;
    ks = '0;
    for (int k = 0; k < W; k++) begin
      ks[k] = s[M-1];
      s     = {s[M-2:0], ^(s & taps)};
    end
    return {s, ks};
  endfunction

  assign w_mode      = r_cfg[CW-1:CW-2];
  assign w_taps_eff  = (r_cfg[2*M-1:M] == '0) ? TAPS_DEFAULT : r_cfg[2*M-1:M];
  assign w_seed_eff  = (r_cfg[M-1:0] == '0) ? SEED_DEFAULT : r_cfg[M-1:0];
  assign w_cfg_load  = r_cfg_en_d & ~cfg_en;
  assign w_bypass    = (w_mode == 2'b01);
  assign w_rx_freeze = (w_mode == 2'b10);

  assign w_tx_run  = lfsr_run(r_tx_lfsr, w_taps_eff);
  assign w_rx_run  = lfsr_run(r_rx_lfsr, w_taps_eff);
  assign w_tx_step = w_tx_run[M+W-1:W];
  assign w_rx_step = w_rx_run[M+W-1:W];
  assign w_tx_ks   = w_bypass ? '0 : w_tx_run[W-1:0];
  assign w_rx_ks   = w_bypass ? '0 : w_rx_run[W-1:0];

  assign tx_ready  = ~cfg_en & ~w_cfg_load & (~r_txo_valid | txo_ready);
  assign rx_ready  = ~cfg_en & ~w_cfg_load & (~r_rxo_valid | rxo_ready);
  assign w_tx_fire = tx_valid & tx_ready;
  assign w_rx_fire = rx_valid & rx_ready;

`ifdef CIPHER_RESYNC_EN
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  logic [FW-1:0] r_tx_cnt, r_rx_cnt;
  logic          w_tx_wrap, w_rx_wrap;

  // The last beat of a frame reloads the seed instead of stepping.
  assign w_tx_wrap     = (r_tx_cnt == FW'(FRAME_LEN - 1));
  assign w_rx_wrap     = (r_rx_cnt == FW'(FRAME_LEN - 1));
  assign w_tx_lfsr_nxt = w_tx_wrap ? w_seed_eff : w_tx_step;
  assign w_rx_lfsr_nxt = w_rx_wrap ? w_seed_eff : w_rx_step;

  always_ff @(posedge clk) begin
    if (rst || w_cfg_load) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_fire) r_tx_cnt <= w_tx_wrap ? '0 : r_tx_cnt + 1'b1;
      if (w_rx_fire) r_rx_cnt <= w_rx_wrap ? '0 : r_rx_cnt + 1'b1;
    end
  end
`else
  assign w_tx_lfsr_nxt = w_tx_step;
  assign w_rx_lfsr_nxt = w_rx_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg       <= '0;
      r_cfg_en_d  <= 1'b0;
      r_tx_lfsr   <= SEED_DEFAULT;
      r_rx_lfsr   <= SEED_DEFAULT;
      r_txo_valid <= 1'b0;
      r_rxo_valid <= 1'b0;
      r_txo_data  <= '0;
      r_rxo_data  <= '0;
    end else begin
      r_cfg_en_d <= cfg_en;
      if (cfg_en) r_cfg <= {r_cfg[CW-2:0], cfg_i};
      if (w_cfg_load) begin
        r_tx_lfsr <= w_seed_eff;
        r_rx_lfsr <= w_seed_eff;
      end else begin
        if (w_tx_fire) r_tx_lfsr <= w_tx_lfsr_nxt;
        if (w_rx_fire && !w_rx_freeze) r_rx_lfsr <= w_rx_lfsr_nxt;
      end
      if (w_tx_fire) begin
        r_txo_valid <= 1'b1;
        r_txo_data  <= tx_data ^ w_tx_ks;
      end else if (txo_ready) begin
        r_txo_valid <= 1'b0;
      end
      if (w_rx_fire) begin
        r_rxo_valid <= 1'b1;
        r_rxo_data  <= rx_data ^ w_rx_ks;
      end else if (rxo_ready) begin
        r_rxo_valid <= 1'b0;
      end
    end
  end

  assign cfg_o     = r_cfg[CW-1];
  assign txo_valid = r_txo_valid;
  assign txo_data  = r_txo_data;
  assign rxo_valid = r_rxo_valid;
  assign rxo_data  = r_rxo_data;
endmodule

// File: tb/tb_lfsr_cipher_duplex.sv
// Directed bench for lfsr_cipher_duplex: a W=1 instance for stream tests and a W=8 instance for byte-wide tests.
// With seed S, keystream bits 0..31 are S[31], S[30], ... S[0], which makes expected ciphertext hand-derivable.
module tb_lfsr_cipher_duplex;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cfg_en, cfg_i, cfg_o, cfg_o8;
  logic       tx_valid, tx_ready, txo_valid, txo_ready;
  logic [0:0] tx_data, txo_data;
  logic       rx_valid, rx_ready, rxo_valid, rxo_ready;
  logic [0:0] rx_data, rxo_data;
  logic       tx8_valid, tx8_ready, txo8_valid, txo8_ready;
  logic [7:0] tx8_data, txo8_data;
  logic       rx8_valid, rx8_ready, rxo8_valid, rxo8_ready;
  logic [7:0] rx8_data, rxo8_data;

  int total = 0;
  int bad = 0;
  int stall_cnt, stall_viol;

  localparam logic [31:0] SEED_V = 32'hB4E15A3C;
  localparam logic [15:0] KS_A   = 16'h872D;  // bit-reverse of SEED_V[31:16]
  localparam logic [15:0] KS_B   = 16'h3C5A;  // bit-reverse of SEED_V[15:0]

  lfsr_cipher_duplex #(.M(32), .W(1)) u_dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .txo_valid(txo_valid), .txo_ready(txo_ready), .txo_data(txo_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rxo_valid(rxo_valid), .rxo_ready(rxo_ready), .rxo_data(rxo_data)
  );

  lfsr_cipher_duplex #(.M(32), .W(8)) u_dut8 (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o8),
    .tx_valid(tx8_valid), .tx_ready(tx8_ready), .tx_data(tx8_data),
    .txo_valid(txo8_valid), .txo_ready(txo8_ready), .txo_data(txo8_data),
    .rx_valid(rx8_valid), .rx_ready(rx8_ready), .rx_data(rx8_data),
    .rxo_valid(rxo8_valid), .rxo_ready(rxo8_ready), .rxo_data(rxo8_data)
  );

  task automatic drive_idle();
    cfg_en = 1'b0; cfg_i = 1'b0;
    tx_valid = 1'b0; tx_data = 1'b0; txo_ready = 1'b1;
    rx_valid = 1'b0; rx_data = 1'b0; rxo_ready = 1'b1;
    tx8_valid = 1'b0; tx8_data = 8'h00; txo8_ready = 1'b1;
    rx8_valid = 1'b0; rx8_data = 8'h00; rxo8_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Shifts v in MSB first; rd/rd8 capture cfg_o before each shift. Returns after the load edge.
  task automatic cfg_shift(input logic [65:0] v, output logic [65:0] rd, output logic [65:0] rd8);
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      rd[65-i]  = cfg_o;
      rd8[65-i] = cfg_o8;
      cfg_en = 1'b1;
      cfg_i  = v[65-i];
    end
    @(negedge clk);
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    @(negedge clk);
  endtask

  // W=1 streams on both channels; txo_ready is low for cycles in [stall_lo, stall_hi).
  task automatic run_stream(input logic [31:0] tx_pt, input logic [31:0] rx_ct, input int n,
                            input int stall_lo, input int stall_hi,
                            output logic [31:0] tx_res, output logic [31:0] rx_res, output int cyc);
    int ti, ri, to, ro;
    logic held_ok;
    logic [0:0] held;
    ti = 0; ri = 0; to = 0; ro = 0; cyc = 0;
    tx_res = '0; rx_res = '0;
    stall_cnt = 0; stall_viol = 0; held_ok = 1'b0; held = 1'b0;
    while ((to < n || ro < n) && cyc < 200) begin
      @(negedge clk);
      tx_valid  = (ti < n);
      tx_data   = (ti < n) ? tx_pt[ti] : 1'b0;
      rx_valid  = (ri < n);
      rx_data   = (ri < n) ? rx_ct[ri] : 1'b0;
      txo_ready = !(cyc >= stall_lo && cyc < stall_hi);
      rxo_ready = 1'b1;
      #1;
      if (txo_valid && !txo_ready) begin
        stall_cnt++;
        if (tx_ready) stall_viol++;
        if (held_ok && txo_data !== held) stall_viol++;
        held = txo_data;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (txo_valid && txo_ready) begin tx_res[to] = txo_data[0]; to++; end
      if (rxo_valid && rxo_ready) begin rx_res[ro] = rxo_data[0]; ro++; end
      if (tx_valid && tx_ready) ti++;
      if (rx_valid && rx_ready) ri++;
      cyc++;
    end
    total++;
    if (to < n || ro < n) begin
      bad++;
      $display("FAIL stream_timeout: got tx=%0d rx=%0d beats, want %0d", to, ro, n);
    end
    @(negedge clk);
    tx_valid = 1'b0; rx_valid = 1'b0; txo_ready = 1'b1; rxo_ready = 1'b1;
  endtask

  // Four back-to-back W=8 TX beats; vmask[k] is txo8_valid seen before edge k.
  task automatic run8(input logic [31:0] pt, output logic [31:0] ct, output logic [4:0] vmask);
    ct = '0; vmask = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tx8_valid  = (k < 4);
      tx8_data   = (k < 4) ? pt[8*k +: 8] : 8'h00;
      txo8_ready = 1'b1;
      #1;
      vmask[k] = txo8_valid;
      if (txo8_valid && k > 0) ct[8*(k-1) +: 8] = txo8_data;
    end
    @(negedge clk);
    tx8_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (txo_valid !== 1'b0) begin bad++; $display("FAIL rst_txo_valid: got %b want 0", txo_valid); end
    total++; if (rxo_valid !== 1'b0) begin bad++; $display("FAIL rst_rxo_valid: got %b want 0", rxo_valid); end
    total++; if (txo_data !== 1'b0 || rxo_data !== 1'b0) begin bad++; $display("FAIL rst_data: got %b/%b want 0/0", txo_data, rxo_data); end
    total++; if (cfg_o !== 1'b0) begin bad++; $display("FAIL rst_cfg_o: got %b want 0", cfg_o); end
    total++; if (tx_ready !== 1'b1 || rx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b/%b want 1/1", tx_ready, rx_ready); end
    total++; if (txo8_valid !== 1'b0 || txo8_data !== 8'h00) begin bad++; $display("FAIL rst_w8: got %b/%h want 0/00", txo8_valid, txo8_data); end
    cfg_en = 1'b1;
    #1;
    total++; if (tx_ready !== 1'b0 || rx_ready !== 1'b0) begin bad++; $display("FAIL cfg_en_ready: got %b/%b want 0/0", tx_ready, rx_ready); end
    cfg_en = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 1'b1; txo_ready = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    #1;
    total++; if (txo_valid !== 1'b1 || txo_data !== 1'b1) begin bad++; $display("FAIL held_beat: got %b/%b want 1/1", txo_valid, txo_data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (txo_valid !== 1'b0 || txo_data !== 1'b0) begin bad++; $display("FAIL rst_mid_beat: got %b/%b want 0/0", txo_valid, txo_data); end
    txo_ready = 1'b1;
  endtask

  task automatic test_defaults();
    logic [65:0] d0, d1;
    logic [31:0] txr, rxr;
    int cyc;
    do_reset();
    cfg_shift(66'h0, d0, d1);
    run_stream(32'h0000F0F0, 32'h0, 16, 0, 0, txr, rxr, cyc);
    total++; if (txr[15:0] !== 16'hF0F0) begin bad++; $display("FAIL default_tx: got %h want f0f0", txr[15:0]); end
    do_reset();
    cfg_shift(66'h0, d0, d1);
    run_stream(32'h0, 32'h0000F0F0, 16, 0, 0, txr, rxr, cyc);
    total++; if (rxr[15:0] !== 16'hF0F0) begin bad++; $display("FAIL default_rx: got %h want f0f0", rxr[15:0]); end
  endtask

  task automatic test_duplex();
    logic [65:0] d0, d1;
    logic [31:0] txr, rxr;
    int cyc;
    do_reset();
    cfg_shift({2'b00, 32'h0, SEED_V}, d0, d1);
    run_stream(32'h00001234, 32'h00009519, 16, 0, 0, txr, rxr, cyc);
    total++; if (txr[15:0] !== 16'h9519) begin bad++; $display("FAIL duplex_tx: got %h want 9519", txr[15:0]); end
    total++; if (rxr[15:0] !== 16'h1234) begin bad++; $display("FAIL duplex_rx: got %h want 1234", rxr[15:0]); end
    total++; if (cyc !== 17) begin bad++; $display("FAIL duplex_throughput: got %0d cycles want 17", cyc); end
  endtask

  task automatic test_bypass();
    logic [65:0] d0, d1;
    logic [31:0] ct, txr, rxr;
    logic [4:0] vm;
    int cyc;
    do_reset();
    cfg_shift({2'b01, 32'h0, SEED_V}, d0, d1);
    run8(32'h3C5A96A5, ct, vm);
    total++; if (ct !== 32'h3C5A96A5) begin bad++; $display("FAIL bypass_data: got %h want 3c5a96a5", ct); end
    total++; if (vm !== 5'b11110) begin bad++; $display("FAIL bypass_latency: got %b want 11110", vm); end
    do_reset();
    cfg_shift({2'b00, 32'h0, SEED_V}, d0, d1);
    run8(32'h0, ct, vm);
    total++; if (ct !== 32'h3C5A872D) begin bad++; $display("FAIL w8_cipher: got %h want 3c5a872d", ct); end
    do_reset();
    cfg_shift({2'b10, 32'h0, SEED_V}, d0, d1);
    run_stream(32'h0, 32'h0, 4, 0, 0, txr, rxr, cyc);
    total++; if (txr[3:0] !== 4'hD) begin bad++; $display("FAIL freeze_tx: got %h want d", txr[3:0]); end
    total++; if (rxr[3:0] !== 4'hF) begin bad++; $display("FAIL freeze_rx: got %h want f", rxr[3:0]); end
  endtask

  task automatic test_backpressure();
    logic [65:0] d0, d1;
    logic [31:0] txr, rxr;
    int cyc;
    do_reset();
    cfg_shift({2'b00, 32'h0, SEED_V}, d0, d1);
    run_stream(32'h4, 32'h0, 4, 1, 6, txr, rxr, cyc);
    total++; if (txr[3:0] !== 4'h9) begin bad++; $display("FAIL bp_data: got %h want 9", txr[3:0]); end
    total++; if (stall_cnt !== 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_cnt); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL bp_ready_or_hold: got %0d violations want 0", stall_viol); end
    total++; if (cyc !== 10) begin bad++; $display("FAIL bp_cycles: got %0d want 10", cyc); end
  endtask

  task automatic test_readback();
    logic [65:0] pat, d0, d1, rd, rd8;
    logic [31:0] ct;
    logic [4:0] vm;
    pat = {2'b10, 32'hDEADBEEF, 32'h13579BDF};
    do_reset();
    cfg_shift(pat, d0, d1);
    cfg_shift(66'h0, rd, rd8);
    total++; if (rd !== pat) begin bad++; $display("FAIL readback: got %h want %h", rd, pat); end
    total++; if (rd8 !== pat) begin bad++; $display("FAIL readback_w8: got %h want %h", rd8, pat); end
    run8(32'h0, ct, vm);
    total++; if (ct !== 32'h80000000) begin bad++; $display("FAIL seed_zero_default: got %h want 80000000", ct); end
  endtask

  task automatic test_resync();
    logic [65:0] d0, d1;
    logic [31:0] txr, rxr, exp_ct;
    int cyc;
`ifdef CIPHER_RESYNC_EN
    exp_ct = {KS_A, KS_A};
`else
    exp_ct = {KS_B, KS_A};
`endif
    do_reset();
    cfg_shift({2'b00, 32'h0, SEED_V}, d0, d1);
    run_stream(32'h0, 32'h0, 32, 0, 0, txr, rxr, cyc);
    total++; if (txr !== exp_ct) begin bad++; $display("FAIL frame_tx: got %h want %h", txr, exp_ct); end
    total++; if (rxr !== exp_ct) begin bad++; $display("FAIL frame_rx: got %h want %h", rxr, exp_ct); end
    total++; if (cyc !== 33) begin bad++; $display("FAIL frame_cycles: got %0d want 33", cyc); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_defaults();
    test_duplex();
    test_bypass();
    test_backpressure();
    test_readback();
    test_resync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
